// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder: operands/start in,
// busy/done and registered result out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder step per RUN cycle, LSB first,
// result and carry-out published together on entry to DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {carry, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (y & c) | (x & c), x ^ y ^ c};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q,  op_a_d;
  logic [WIDTH-1:0] op_b_q,  op_b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic [1:0]       fa_s;

  // Next-state and datapath step for the serial addition.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    fa_s    = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        fa_s    = full_add(op_a_q[0], op_b_q[0], carry_q);
        // New sum bit enters at the MSB so bit i lands in place after WIDTH shifts.
        res_d   = (res_q >> 1) | (WIDTH'(fa_s[0]) << (WIDTH - 1));
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        carry_d = fa_s[1];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
          sum_d   = res_d;
          cout_d  = fa_s[1];
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 1, 8 and 32 against an
// arithmetic reference ({cout,sum} = a + b + cin, done in cycle WIDTH+1).
module tb_serial_adder;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  logic [31:0] last_sum [3];
  logic        last_cout[3];

  serial_adder_if #(.WIDTH(1))  if1 ();
  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx(input int w);
    return (w == 1) ? 0 : ((w == 8) ? 1 : 2);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
    case (w)
      1: begin
        if1.start = st; if1.a = a[0:0]; if1.b = b[0:0]; if1.cin = c;
      end
      8: begin
        if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = c;
      end
      default: begin
        if32.start = st; if32.a = a; if32.b = b; if32.cin = c;
      end
    endcase
  endtask

  task automatic sample(input int w, output logic bsy, output logic dn,
                        output logic [31:0] sm, output logic co);
    case (w)
      1: begin
        bsy = if1.busy; dn = if1.done; sm = 32'(if1.sum); co = if1.cout;
      end
      8: begin
        bsy = if8.busy; dn = if8.done; sm = 32'(if8.sum); co = if8.cout;
      end
      default: begin
        bsy = if32.busy; dn = if32.done; sm = if32.sum; co = if32.cout;
      end
    endcase
  endtask

  // One addition: start now, optionally poke start at cycle intr_cyc or
  // pulse rst at cycle rst_cyc (0 disables either).
  task automatic op(input int w, input logic [31:0] a, input logic [31:0] b,
                    input logic c, input int intr_cyc, input int rst_cyc,
                    input string tag);
    logic [63:0] mask;
    logic [63:0] full;
    logic        bsy, dn, co;
    logic [31:0] sm;
    int          k;
    int          cyc;
    k    = idx(w);
    mask = (64'd1 << w) - 64'd1;
    full = (64'(a) & mask) + (64'(b) & mask) + 64'(c);
    drive(w, 1'b1, a, b, c);
    @(posedge clk); #1;
    drive(w, 1'b0, a, b, c);
    cyc = 1;
    while (cyc <= w + 1) begin
      sample(w, bsy, dn, sm, co);
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sample(w, bsy, dn, sm, co);
        chk({tag, "_rst_busy"}, 64'(bsy), 64'd0);
        chk({tag, "_rst_done"}, 64'(dn),  64'd0);
        chk({tag, "_rst_sum"},  64'(sm),  64'd0);
        chk({tag, "_rst_cout"}, 64'(co),  64'd0);
        for (int i = 0; i < w + 2; i++) begin
          @(posedge clk); #1;
          sample(w, bsy, dn, sm, co);
          chk({tag, "_rst_nodone"}, 64'(dn),  64'd0);
          chk({tag, "_rst_idle"},   64'(bsy), 64'd0);
        end
        for (int j = 0; j < 3; j++) begin
          last_sum[j]  = 32'd0;
          last_cout[j] = 1'b0;
        end
        return;
      end
      if (cyc < w + 1) begin
        chk({tag, "_run_done"}, 64'(dn),  64'd0);
        chk({tag, "_run_busy"}, 64'(bsy), 64'd1);
        chk({tag, "_run_sum"},  64'(sm),  64'(last_sum[k]));
        chk({tag, "_run_cout"}, 64'(co),  64'(last_cout[k]));
      end else begin
        chk({tag, "_done"},      64'(dn),  64'd1);
        chk({tag, "_done_busy"}, 64'(bsy), 64'd1);
        chk({tag, "_sum"},       64'(sm),  full & mask);
        chk({tag, "_cout"},      64'(co),  64'(full[w]));
      end
      if (cyc == intr_cyc) begin
        drive(w, 1'b1, $urandom, $urandom, 1'($urandom));
      end else begin
        drive(w, 1'b0, a, b, c);
      end
      @(posedge clk); #1;
      cyc++;
    end
    sample(w, bsy, dn, sm, co);
    chk({tag, "_after_done"}, 64'(dn),  64'd0);
    chk({tag, "_after_busy"}, 64'(bsy), 64'd0);
    chk({tag, "_hold_sum"},   64'(sm),  full & mask);
    chk({tag, "_hold_cout"},  64'(co),  64'(full[w]));
    last_sum[k]  = 32'(full & mask);
    last_cout[k] = full[w];
  endtask

  logic [2:0]  v;
  logic        bsy0, dn0, co0;
  logic [31:0] sm0;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1,  1'b0, 32'd0, 32'd0, 1'b0);
    drive(8,  1'b0, 32'd0, 32'd0, 1'b0);
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      last_sum[j]  = 32'd0;
      last_cout[j] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    sample(1, bsy0, dn0, sm0, co0);
    chk("reset_w1_busy", 64'(bsy0), 64'd0);
    chk("reset_w1_done", 64'(dn0),  64'd0);
    sample(8, bsy0, dn0, sm0, co0);
    chk("reset_w8_busy", 64'(bsy0), 64'd0);
    chk("reset_w8_sum",  64'(sm0),  64'd0);
    chk("reset_w8_cout", 64'(co0),  64'd0);
    sample(32, bsy0, dn0, sm0, co0);
    chk("reset_w32_done", 64'(dn0), 64'd0);
    chk("reset_w32_sum",  64'(sm0), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      op(1, {31'd0, v[2]}, {31'd0, v[1]}, v[0], 0, 0, "w1_tt");
    end

    // WIDTH=8 directed cases
    op(8, 32'h5A, 32'h3C, 1'b1, 0, 0, "w8_5a_3c");
    op(8, 32'hFF, 32'h01, 1'b0, 0, 0, "w8_ff_01");
    op(8, 32'hFF, 32'hFF, 1'b1, 0, 0, "w8_ff_ff_b2b");
    op(8, 32'h10, 32'h20, 1'b0, 3, 0, "w8_busy_start");
    op(8, 32'h77, 32'h99, 1'b1, 0, 4, "w8_rst_abort");
    op(8, 32'h01, 32'h01, 1'b0, 0, 0, "w8_after_rst");
    for (int i = 0; i < 6; i++) begin
      op(8, $urandom, $urandom, 1'($urandom), 0, 0, "w8_rand");
    end

    // WIDTH=32 cases
    op(32, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 0, "w32_ones");
    for (int i = 0; i < 4; i++) begin
      op(32, $urandom, $urandom, 1'($urandom), 0, 0, "w32_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits, legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset sampled on the clk rising edge.
REQ-004 The block SHALL have port start, input, 1, request to begin an addition; sampled only when busy=0.
REQ-005 The block SHALL have port a, input, WIDTH, first operand; sampled with start.
REQ-006 The block SHALL have port b, input, WIDTH, second operand; sampled with start.
REQ-007 The block SHALL have port cin, input, 1, carry-in; sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high while an addition is in progress or completing; start ignored.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking the result as newly valid.
REQ-010 The block SHALL have port sum, output, WIDTH, registered result bits.
REQ-011 The block SHALL have port cout, output, 1, registered carry-out.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 at an edge SHALL load a and b into operand shift registers, cin into the carry register, and clear the bit counter.
REQ-014 The IDLE-to-RUN transition SHALL occur on that same edge.
REQ-015 In IDLE, start=0 SHALL leave all state unchanged.
REQ-016 Each RUN edge SHALL add the operand-register LSBs and the carry register using a 1-bit full adder: sum bit = a^b^c, carry = ab|bc|ac.
REQ-017 Each RUN edge SHALL shift the sum bit into the MSB of an internal result shift register.
REQ-018 Each RUN edge SHALL shift both operand registers right by one, store the new carry, and increment the counter.
REQ-019 After exactly WIDTH RUN edges, the FSM SHALL enter DONE; sum bit i comes from the i-th RUN edge (LSB first).
REQ-020 On the RUN-to-DONE edge, sum SHALL load the complete internal result and cout SHALL load the final carry.
REQ-021 done SHALL be 1 only while in DONE; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-022 Latency: if start is sampled at the end of cycle 0, done SHALL be high in cycle WIDTH+1.
REQ-023 Throughput: the next start SHALL be acceptable in cycle WIDTH+2.
REQ-024 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored, with no effect on operands, carry, or counter.
REQ-026 sum and cout SHALL hold their last values from REQ-020 until the next DONE entry.
REQ-027 sum and cout SHALL NOT change during RUN.
REQ-028 Arithmetic SHALL satisfy {cout,sum} = a + b + cin exactly for all input values; overflow appears only in cout.
REQ-029 The counter SHALL be wide enough to count to WIDTH without wrap; for WIDTH=1, RUN SHALL last exactly one cycle.
REQ-030 The block SHALL contain no combinational path from inputs to outputs; all outputs SHALL be registered.

Reset
REQ-031 rst=1 SHALL force state to IDLE and clear busy, done, sum, cout, the operand, carry, and result registers, and the counter, on the next edge.
REQ-032 rst SHALL take priority over start.
REQ-033 rst asserted in RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-034 The first start after rst deasserts SHALL behave per REQ-013..REQ-022.

Verification
REQ-035 WIDTH=1, all 8 {a,b,cin} combinations -> {cout,sum} matches the full-adder truth table (e.g. 1,1,1 -> cout=1, sum=1); done in cycle 2 each time.
REQ-036 WIDTH=8, a=0x5A, b=0x3C, cin=1 -> sum=0x97, cout=0, with done high exactly 9 cycles after the start cycle and for one cycle only.
REQ-037 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 issued at the first legal cycle -> sum=0xFF, cout=1.
REQ-038 WIDTH=8, start with a=0x10, b=0x20, cin=0, then start with a=0xFF, b=0xFF during RUN cycle 3 -> second start ignored; sum=0x30, cout=0.
REQ-039 WIDTH=8, rst pulsed during RUN cycle 4 -> busy=0, sum=0x00, cout=0 next cycle, no done; the following start with a=0x01, b=0x01 -> sum=0x02.
REQ-040 WIDTH=32, a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, done in cycle 33.
